uart_cmd_engine: RTL and testbench

Byte-level command responder on the far side of the UART FIFO interface. It pops received bytes from the UART RX FIFO, parses fixed-length read/write frames addressed to a small 8-bit register bank, and pushes reply bytes into the UART TX FIFO. It sits between the `uart` block and the rest of the design, and exposes the register bank as a flat output bus.

---
 rtl/uart_cmd_pkg.sv | 19 +
 rtl/uart_cmd_regfile.sv | 42 ++++
 rtl/uart_cmd_engine.sv | 140 ++++++++++++++
 tb/tb_uart_cmd_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and parser state encoding for the UART command engine.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    SEND0,
    SEND1,
    ERR
  } state_t;

endpackage

// File: rtl/uart_cmd_regfile.sv
// NUM_REGS x 8 register bank: one write port, combinational read mux, flat output bus.
module uart_cmd_regfile #(
  parameter int NUM_REGS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [7:0]            rd_addr,
  output logic [7:0]            rd_data,
  output logic [NUM_REGS*8-1:0] reg_out
);

  logic [7:0] regs_reg [NUM_REGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_reg <= '{default: '0};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && wr_addr == 8'(i)) regs_reg[i] <= wr_data;
      end
    end
  end

  // Out-of-range addresses read as zero; the engine never uses that value.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 8'(i)) rd_data = regs_reg[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign reg_out[gi*8 +: 8] = regs_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/uart_cmd_engine.sv
// Parses W/R frames popped from the UART RX FIFO, drives the register bank
// and pushes replies into the UART TX FIFO.
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 270000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_fifo_empty,
  input  logic [7:0]            rx_fifo_data_out,
  output logic                  rx_fifo_read_en,
  input  logic                  tx_ready,
  output logic [7:0]            tx_fifo_data_in,
  output logic                  tx_fifo_write_en,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  reg_wr_strobe,
  output logic [7:0]            reg_wr_addr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [7:0]       op_reg, addr_reg, data_reg;
  logic [7:0]       tx_data_reg, tx_hold_reg, wr_addr_reg;
  logic             two_byte_reg, popped_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pop, push, timeout, reg_we, addr_ok, in_frame;
  logic [7:0]       rd_data;

  assign addr_ok  = ({1'b0, addr_reg} < 9'(NUM_REGS));
  assign in_frame = (state_reg == GET_ADDR) || (state_reg == GET_DATA);

  // Strobes are gated by reset so nothing leaks out while it is held.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    push       = 1'b0;
    timeout    = 1'b0;
    reg_we     = 1'b0;
    case (state_reg)
      IDLE, GET_ADDR, GET_DATA: begin
        pop     = !rx_fifo_empty && !popped_reg && !reset;
        timeout = in_frame && !pop && (cnt_reg == CNT_LAST);
        if (pop) begin
          case (state_reg)
            IDLE:     state_next = (rx_fifo_data_out == OP_WRITE || rx_fifo_data_out == OP_READ)
                                   ? GET_ADDR : ERR;
            GET_ADDR: state_next = (op_reg == OP_WRITE) ? GET_DATA : EXEC;
            default:  state_next = EXEC;
          endcase
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      EXEC: begin
        reg_we     = (op_reg == OP_WRITE) && addr_ok && !reset;
        state_next = SEND0;
      end
      SEND0: begin
        push = tx_ready && !reset;
        if (push) state_next = two_byte_reg ? SEND1 : IDLE;
      end
      SEND1: begin
        push = tx_ready && !reset;
        if (push) state_next = IDLE;
      end
      ERR:     state_next = SEND0;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      tx_data_reg  <= '0;
      tx_hold_reg  <= '0;
      wr_addr_reg  <= '0;
      two_byte_reg <= 1'b0;
      popped_reg   <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg  <= state_next;
      popped_reg <= pop;
      if (pop) begin
        case (state_reg)
          IDLE:     op_reg   <= rx_fifo_data_out;
          GET_ADDR: addr_reg <= rx_fifo_data_out;
          default:  data_reg <= rx_fifo_data_out;
        endcase
      end
      if (in_frame && !pop && !timeout) cnt_reg <= cnt_reg + CNT_W'(1);
      else                              cnt_reg <= '0;
      if (reg_we) wr_addr_reg <= addr_reg;
      case (state_reg)
        EXEC: begin
          two_byte_reg <= 1'b0;
          if (!addr_ok) begin
            tx_data_reg <= RSP_ERR;
          end else if (op_reg == OP_WRITE) begin
            tx_data_reg <= RSP_ACK;
          end else begin
            tx_data_reg  <= OP_READ;
            tx_hold_reg  <= rd_data;
            two_byte_reg <= 1'b1;
          end
        end
        ERR: begin
          tx_data_reg  <= RSP_ERR;
          two_byte_reg <= 1'b0;
        end
        SEND0:   if (push && two_byte_reg) tx_data_reg <= tx_hold_reg;
        default: ;
      endcase
    end
  end

  uart_cmd_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (reg_we),
    .wr_addr (addr_reg),
    .wr_data (data_reg),
    .rd_addr (addr_reg),
    .rd_data (rd_data),
    .reg_out (reg_out)
  );

  assign rx_fifo_read_en  = pop;
  assign tx_fifo_write_en = push;
  assign tx_fifo_data_in  = tx_data_reg;
  assign reg_wr_strobe    = reg_we;
  assign reg_wr_addr      = wr_addr_reg;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Bench for uart_cmd_engine: FIFO models, frame-level reference model, directed and random frames.
module tb_uart_cmd_engine;

  localparam int NREGS = 16;
  localparam int TMO   = 200;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               rx_fifo_empty = 1'b1;
  logic [7:0]         rx_fifo_data_out = 8'h00;
  logic               rx_fifo_read_en;
  logic               tx_ready = 1'b1;
  logic [7:0]         tx_fifo_data_in;
  logic               tx_fifo_write_en;
  logic [NREGS*8-1:0] reg_out;
  logic               reg_wr_strobe;
  logic [7:0]         reg_wr_addr;

  uart_cmd_engine #(.NUM_REGS(NREGS), .TIMEOUT_CYCLES(TMO)) dut (
    .clock            (clock),
    .reset            (reset),
    .rx_fifo_empty    (rx_fifo_empty),
    .rx_fifo_data_out (rx_fifo_data_out),
    .rx_fifo_read_en  (rx_fifo_read_en),
    .tx_ready         (tx_ready),
    .tx_fifo_data_in  (tx_fifo_data_in),
    .tx_fifo_write_en (tx_fifo_write_en),
    .reg_out          (reg_out),
    .reg_wr_strobe    (reg_wr_strobe),
    .reg_wr_addr      (reg_wr_addr)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_pop_cyc = -10;
  int         wr_cnt = 0;
  int         exp_wr = 0;
  logic       rand_ready = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_got[$];
  int         tx_cyc[$];
  logic [7:0] mregs [NREGS];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic rx_update();
    rx_fifo_empty    = (rx_q.size() == 0);
    rx_fifo_data_out = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  function automatic logic [127:0] model_bank();
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < NREGS; i++) b[i*8 +: 8] = mregs[i];
    return b;
  endfunction

  // One clock: observe strobes mid-cycle, then apply FIFO pops just after the edge.
  task automatic tick();
    logic pop_now;
    pop_now = 1'b0;
    @(negedge clock);
    cyc++;
    if (reset)
      check("reset_quiet", 128'({rx_fifo_read_en, tx_fifo_write_en, reg_wr_strobe}), 128'(0));
    if (rx_fifo_read_en) begin
      check("pop_spacing", 128'(cyc - last_pop_cyc >= 2), 128'(1));
      check("pop_nonempty", 128'(rx_q.size() != 0), 128'(1));
      last_pop_cyc = cyc;
      pop_now = 1'b1;
    end
    if (tx_fifo_write_en) begin
      check("push_ready", 128'(tx_ready), 128'(1));
      tx_got.push_back(tx_fifo_data_in);
      tx_cyc.push_back(cyc);
    end
    if (reg_wr_strobe) begin
      wr_cnt++;
      check("wr_strobe_latency", 128'(cyc - last_pop_cyc), 128'(1));
    end
    @(posedge clock);
    #1;
    if (pop_now && rx_q.size() != 0) void'(rx_q.pop_front());
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    rx_update();
  endtask

  // Reference model: whole frames in, expected reply bytes and register effects out.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    rx_q.push_back(b0);
    if (b0 == 8'h57) begin
      rx_q.push_back(b1);
      rx_q.push_back(b2);
      if (b1 < NREGS) begin
        mregs[b1[3:0]] = b2;
        exp_q.push_back(8'h4B);
        exp_wr++;
      end else begin
        exp_q.push_back(8'h3F);
      end
    end else if (b0 == 8'h52) begin
      rx_q.push_back(b1);
      if (b1 < NREGS) begin
        exp_q.push_back(8'h52);
        exp_q.push_back(mregs[b1[3:0]]);
      end else begin
        exp_q.push_back(8'h3F);
      end
    end else begin
      exp_q.push_back(8'h3F);
    end
    rx_update();
  endtask

  task automatic drain(input string tag, input bit chk_lat);
    int n;
    n = 0;
    while ((tx_got.size() < exp_q.size() || rx_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_budget"}, 128'(n < 2000), 128'(1));
    repeat (6) tick();
    check({tag, "_count"}, 128'(tx_got.size()), 128'(exp_q.size()));
    if (chk_lat && tx_cyc.size() > 0)
      check({tag, "_lat0"}, 128'(tx_cyc[0] - last_pop_cyc), 128'(2));
    if (chk_lat && tx_cyc.size() > 1)
      check({tag, "_lat1"}, 128'(tx_cyc[1] - last_pop_cyc), 128'(3));
    for (int i = 0; i < exp_q.size() && i < tx_got.size(); i++)
      check({tag, "_byte"}, 128'(tx_got[i]), 128'(exp_q[i]));
    check({tag, "_bank"}, 128'(reg_out), model_bank());
    check({tag, "_wrcnt"}, 128'(wr_cnt), 128'(exp_wr));
    exp_q.delete();
    tx_got.delete();
    tx_cyc.delete();
  endtask

  initial begin
    logic [7:0] op, a, d;
    int kind;
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;

    // Reset state, with a junk byte already waiting in the RX FIFO.
    rx_q.push_back(8'h41);
    rx_update();
    repeat (3) tick();
    check("rst_tx_data", 128'(tx_fifo_data_in), 128'(0));
    check("rst_reg_out", 128'(reg_out), 128'(0));
    check("rst_wr_addr", 128'(reg_wr_addr), 128'(0));
    reset = 1'b0;
    exp_q.push_back(8'h3F);
    drain("init_junk", 1'b0);

    send_frame(8'h57, 8'h03, 8'hA5);
    drain("write", 1'b1);
    check("write_reg3", 128'(reg_out[31:24]), 128'(8'hA5));
    check("write_addr", 128'(reg_wr_addr), 128'(8'h03));

    send_frame(8'h57, 8'h00, 8'h5A);
    send_frame(8'h52, 8'h00, 8'h00);
    drain("raw", 1'b0);

    send_frame(8'h41, 8'h00, 8'h00);
    send_frame(8'h57, 8'h10, 8'hFF);
    drain("errors", 1'b0);
    send_frame(8'h52, 8'hFF, 8'h00);
    drain("rd_oob", 1'b0);

    tx_ready = 1'b0;
    send_frame(8'h52, 8'h03, 8'h00);
    repeat (50) tick();
    check("bp_nopush", 128'(tx_got.size()), 128'(0));
    tx_ready = 1'b1;
    drain("backpressure", 1'b0);

    // Partial frame abandoned: no reply, next frame parsed from its opcode.
    rx_q.push_back(8'h57);
    rx_update();
    repeat (TMO + 20) tick();
    check("tmo_noreply", 128'(tx_got.size()), 128'(0));
    send_frame(8'h52, 8'h01, 8'h00);
    drain("after_tmo", 1'b0);

    // Gaps shorter than the timeout must not break a frame.
    rx_q.push_back(8'h57);
    rx_update();
    repeat (TMO - 20) tick();
    rx_q.push_back(8'h07);
    rx_q.push_back(8'h3C);
    rx_update();
    mregs[7] = 8'h3C;
    exp_q.push_back(8'h4B);
    exp_wr++;
    drain("slow_frame", 1'b0);

    // Reset in the middle of a write frame.
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h02);
    rx_update();
    repeat (8) tick();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    check("midrst_reg_out", 128'(reg_out), 128'(0));
    check("midrst_wr_addr", 128'(reg_wr_addr), 128'(0));
    send_frame(8'h52, 8'h02, 8'h00);
    drain("midrst_read", 1'b1);

    // Random frames with random TX back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 9));
      a    = 8'($urandom_range(0, 19));
      d    = 8'($urandom);
      op   = 8'($urandom);
      if (op == 8'h57 || op == 8'h52) op = 8'h41;
      if (kind < 4)      op = 8'h57;
      else if (kind < 8) op = 8'h52;
      send_frame(op, a, d);
      drain("random", 1'b0);
    end
    rand_ready = 1'b0;
    tx_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
